// File: rtl/rx_audio_xfer_sched_if.sv
// Host/producer/memory-facing signals of the rx audio read scheduler.
interface rx_audio_xfer_sched_if;
  logic [15:0] buf_ctr_C;
  logic [7:0]  nrx_samps;
  logic        start_C;
  logic        word_rdy_C;
  logic        get_rx_samp_C;
  logic        busy_C;
  logic        done_C;
  logic [15:0] avail_C;
  logic        overrun_C;
  logic        reset_bufs_C;

  modport master (
    output buf_ctr_C, nrx_samps, start_C, word_rdy_C,
    input  get_rx_samp_C, busy_C, done_C, avail_C, overrun_C, reset_bufs_C
  );

  modport slave (
    input  buf_ctr_C, nrx_samps, start_C, word_rdy_C,
    output get_rx_samp_C, busy_C, done_C, avail_C, overrun_C, reset_bufs_C
  );
endinterface

// File: rtl/rx_audio_xfer_sched.sv
// CPU-domain read scheduler for the shared rx audio sample buffer: one paced burst per request.
// Optional writer-overrun detection and recovery is enabled with `define RX_XFER_OVERRUN_EN.
module rx_audio_xfer_sched #(
  parameter int unsigned CHANS     = 4,
  parameter int unsigned BUF_DEPTH = 8
) (
  input  logic                  cpu_clk,
  input  logic                  reset_C,
  rx_audio_xfer_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_READ    = 3'd2,
    S_DONE    = 3'd3,
    S_RECOVER = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] rd_ctr_q, rd_ctr_d;
  logic [15:0] rem_q, rem_d;
  logic        overrun_q, overrun_d;
  logic        reset_bufs_q, reset_bufs_d;
  logic [15:0] avail_s;
  logic [15:0] words_s;
  logic        strobe_s;
  logic        ovr_s;

  if ((CHANS == 0) || (BUF_DEPTH == 0)) begin : g_bad_cfg
    $error("rx_audio_xfer_sched: CHANS and BUF_DEPTH must be non-zero");
  end

  // Pending buffers; modular subtraction keeps this right across producer-counter wrap.
  assign avail_s = bus.buf_ctr_C - rd_ctr_q;
  assign words_s = 16'(bus.nrx_samps) * 16'(CHANS * 3) + 16'd4;

`ifdef RX_XFER_OVERRUN_EN
  assign ovr_s = (state_q != S_RECOVER) && (avail_s > 16'(BUF_DEPTH));
`else
  assign ovr_s = 1'b0;
`endif

  // Next-state, counter update and strobe decode.
  always_comb begin
    state_d      = state_q;
    rd_ctr_d     = rd_ctr_q;
    rem_d        = rem_q;
    overrun_d    = overrun_q;
    reset_bufs_d = 1'b0;
    strobe_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_C && (bus.nrx_samps != 8'd0)) begin
          rem_d   = words_s;
          state_d = (avail_s != 16'd0) ? S_READ : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (avail_s != 16'd0) begin
          state_d = S_READ;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_READ: begin
        strobe_s = bus.word_rdy_C;
        if (bus.word_rdy_C) begin
          rem_d   = rem_q - 16'd1;
          state_d = (rem_q == 16'd1) ? S_DONE : S_READ;
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE: begin
        rd_ctr_d = rd_ctr_q + 16'd1;
        state_d  = S_IDLE;
      end
      S_RECOVER: begin
        if (bus.buf_ctr_C == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RECOVER;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Overrun wins over everything, including a final strobe heading for DONE.
    if (ovr_s) begin
      state_d      = S_RECOVER;
      reset_bufs_d = 1'b1;
      overrun_d    = 1'b1;
      rd_ctr_d     = 16'd0;
      rem_d        = 16'd0;
    end else begin
      reset_bufs_d = reset_bufs_d;
    end
  end

  // State and counter registers.
  always_ff @(posedge cpu_clk) begin
    if (reset_C) begin
      state_q      <= S_IDLE;
      rd_ctr_q     <= 16'd0;
      rem_q        <= 16'd0;
      overrun_q    <= 1'b0;
      reset_bufs_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ctr_q     <= rd_ctr_d;
      rem_q        <= rem_d;
      overrun_q    <= overrun_d;
      reset_bufs_q <= reset_bufs_d;
    end
  end

  assign bus.get_rx_samp_C = strobe_s;
  assign bus.busy_C        = (state_q != S_IDLE);
  assign bus.done_C        = (state_q == S_DONE);
  assign bus.avail_C       = avail_s;
  assign bus.overrun_C     = overrun_q;
  assign bus.reset_bufs_C  = reset_bufs_q;

endmodule

// File: tb/tb_rx_audio_xfer_sched.sv
// Self-checking bench for rx_audio_xfer_sched: vector table, directed corner sequences, random bursts vs model.
module tb_rx_audio_xfer_sched;
  localparam int unsigned CHANS     = 4;
  localparam int unsigned BUF_DEPTH = 8;

  logic cpu_clk = 1'b0;
  logic reset_C;
  rx_audio_xfer_sched_if bus();

  rx_audio_xfer_sched #(.CHANS(CHANS), .BUF_DEPTH(BUF_DEPTH)) dut (
    .cpu_clk (cpu_clk),
    .reset_C (reset_C),
    .bus     (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_strobe = 0;
  int n_done = 0;
  int n_rbufs = 0;
  logic        s_strobe, s_busy, s_done, s_over, s_rbufs;
  logic [15:0] s_avail;

  typedef struct packed {
    logic        rst;
    logic [15:0] buf_ctr;
    logic [7:0]  nrx;
    logic        start;
    logic        rdy;
    logic        get;
    logic        busy;
    logic        done;
    logic        over;
    logic [15:0] avail;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are driven just after a rising edge; outputs are sampled on the falling edge.
  task automatic run_cyc();
    @(negedge cpu_clk);
    s_strobe = bus.get_rx_samp_C;
    s_busy   = bus.busy_C;
    s_done   = bus.done_C;
    s_over   = bus.overrun_C;
    s_rbufs  = bus.reset_bufs_C;
    s_avail  = bus.avail_C;
    if (s_strobe) n_strobe++;
    if (s_done)   n_done++;
    if (s_rbufs)  n_rbufs++;
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_reset();
    reset_C = 1'b1;
    bus.start_C = 1'b0;
    run_cyc();
    reset_C = 1'b0;
  endtask

  task automatic clr_cnt();
    n_strobe = 0;
    n_done   = 0;
    n_rbufs  = 0;
  endtask

  initial begin
    int unsigned model_rd;
    reset_C = 1'b1;
    bus.buf_ctr_C = 16'd0;
    bus.nrx_samps = 8'd0;
    bus.start_C = 1'b0;
    bus.word_rdy_C = 1'b0;
    @(posedge cpu_clk);
    #1;

    //          rst   buf      nrx    st    rdy   get   busy  done  over  avail
    vt[0] = '{1'b1, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[1] = '{1'b0, 16'd3, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3};
    vt[2] = '{1'b0, 16'd3, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3};
    vt[3] = '{1'b0, 16'd0, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[4] = '{1'b0, 16'd0, 8'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    vt[5] = '{1'b0, 16'd0, 8'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    vt[6] = '{1'b1, 16'd0, 8'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    vt[7] = '{1'b0, 16'd0, 8'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[8] = '{1'b0, 16'd2, 8'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
    vt[9] = '{1'b0, 16'd5, 8'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};
    foreach (vt[i]) begin
      reset_C        = vt[i].rst;
      bus.buf_ctr_C  = vt[i].buf_ctr;
      bus.nrx_samps  = vt[i].nrx;
      bus.start_C    = vt[i].start;
      bus.word_rdy_C = vt[i].rdy;
      run_cyc();
      chk($sformatf("vec%0d.get", i),   32'(s_strobe), 32'(vt[i].get));
      chk($sformatf("vec%0d.busy", i),  32'(s_busy),   32'(vt[i].busy));
      chk($sformatf("vec%0d.done", i),  32'(s_done),   32'(vt[i].done));
      chk($sformatf("vec%0d.over", i),  32'(s_over),   32'(vt[i].over));
      chk($sformatf("vec%0d.avail", i), 32'(s_avail),  32'(vt[i].avail));
    end
    bus.start_C = 1'b0;

    // Full 2044-word burst; nrx_samps changes mid-burst must not matter.
    do_reset();
    bus.buf_ctr_C = 16'd1; bus.nrx_samps = 8'd170; bus.word_rdy_C = 1'b1;
    bus.start_C = 1'b1; run_cyc(); bus.start_C = 1'b0;
    chk("t1_start_busy", 32'(s_busy), 32'd0);
    clr_cnt();
    for (int i = 0; i < 2044; i++) begin
      if (i == 10) bus.nrx_samps = 8'd1;
      run_cyc();
    end
    chk("t1_strobes", 32'(n_strobe), 32'd2044);
    chk("t1_no_early_done", 32'(n_done), 32'd0);
    run_cyc();
    chk("t1_done", 32'(s_done), 32'd1);
    chk("t1_done_busy", 32'(s_busy), 32'd1);
    chk("t1_done_nostrobe", 32'(s_strobe), 32'd0);
    chk("t1_done_avail", 32'(s_avail), 32'd1);
    run_cyc();
    chk("t1_idle_busy", 32'(s_busy), 32'd0);
    chk("t1_idle_done", 32'(s_done), 32'd0);
    chk("t1_avail_after", 32'(s_avail), 32'd0);

    // Request with nothing pending waits, then starts the cycle after a buffer lands.
    do_reset();
    bus.buf_ctr_C = 16'd0; bus.nrx_samps = 8'd1; bus.word_rdy_C = 1'b1;
    bus.start_C = 1'b1; run_cyc(); bus.start_C = 1'b0;
    clr_cnt();
    repeat (5) run_cyc();
    chk("t2_wait_busy", 32'(s_busy), 32'd1);
    chk("t2_wait_nostrobe", 32'(n_strobe), 32'd0);
    bus.buf_ctr_C = 16'd1;
    run_cyc();
    chk("t2_arrive_cycle", 32'(s_strobe), 32'd0);
    run_cyc();
    chk("t2_first_strobe", 32'(s_strobe), 32'd1);
    repeat (15) run_cyc();
    chk("t2_strobes", 32'(n_strobe), 32'd16);
    run_cyc();
    chk("t2_done", 32'(s_done), 32'd1);
    run_cyc();
    chk("t2_idle", 32'(s_busy), 32'd0);

    // Alternating word_rdy: 16 strobes over 31 cycles, remaining count held on stalls.
    bus.buf_ctr_C = 16'd2; bus.word_rdy_C = 1'b0;
    bus.start_C = 1'b1; run_cyc(); bus.start_C = 1'b0;
    clr_cnt();
    for (int i = 0; i < 31; i++) begin
      bus.word_rdy_C = ((i % 2) == 0);
      run_cyc();
      if (i == 1) chk("t3_stall", 32'(s_strobe), 32'd0);
    end
    chk("t3_strobes", 32'(n_strobe), 32'd16);
    chk("t3_no_early_done", 32'(n_done), 32'd0);
    bus.word_rdy_C = 1'b0;
    run_cyc();
    chk("t3_done", 32'(s_done), 32'd1);
    run_cyc();
    chk("t3_avail", 32'(s_avail), 32'd0);

`ifndef RX_XFER_OVERRUN_EN
    // Consumed count is 2: producer count wrapping through 0xFFFF stays modular.
    bus.buf_ctr_C = 16'd1;      run_cyc(); chk("wrap_a", 32'(s_avail), 32'hFFFF);
    bus.buf_ctr_C = 16'hFFFF;   run_cyc(); chk("wrap_b", 32'(s_avail), 32'hFFFD);
    bus.buf_ctr_C = 16'h0000;   run_cyc(); chk("wrap_c", 32'(s_avail), 32'hFFFE);
    bus.buf_ctr_C = 16'h0003; bus.word_rdy_C = 1'b1;
    bus.start_C = 1'b1; run_cyc(); bus.start_C = 1'b0;
    chk("wrap_d", 32'(s_avail), 32'd1);
    clr_cnt();
    repeat (17) run_cyc();
    chk("wrap_strobes", 32'(n_strobe), 32'd16);
    chk("wrap_done", 32'(s_done), 32'd1);
    run_cyc();
    chk("wrap_avail", 32'(s_avail), 32'd0);
`endif

    // Producer laps the reader mid-burst.
    do_reset();
    bus.buf_ctr_C = 16'd1; bus.nrx_samps = 8'd170; bus.word_rdy_C = 1'b1;
    bus.start_C = 1'b1; run_cyc(); bus.start_C = 1'b0;
    clr_cnt();
    repeat (100) run_cyc();
    bus.buf_ctr_C = 16'd9;
    run_cyc();
    chk("t5_strobe_at_lap", 32'(s_strobe), 32'd1);
    chk("t5_avail", 32'(s_avail), 32'd9);
`ifdef RX_XFER_OVERRUN_EN
    run_cyc();
    chk("t5_rbufs", 32'(s_rbufs), 32'd1);
    chk("t5_over", 32'(s_over), 32'd1);
    chk("t5_nostrobe", 32'(s_strobe), 32'd0);
    chk("t5_busy", 32'(s_busy), 32'd1);
    repeat (10) run_cyc();
    chk("t5_rbufs_once", 32'(n_rbufs), 32'd1);
    chk("t5_strobes", 32'(n_strobe), 32'd101);
    chk("t5_no_done", 32'(n_done), 32'd0);
    bus.buf_ctr_C = 16'd0;
    run_cyc();
    chk("t5_recover_hold", 32'(s_busy), 32'd1);
    run_cyc();
    chk("t5_idle", 32'(s_busy), 32'd0);
    chk("t5_sticky", 32'(s_over), 32'd1);
    chk("t5_avail0", 32'(s_avail), 32'd0);
`else
    repeat (2044 - 101) run_cyc();
    chk("t5_strobes", 32'(n_strobe), 32'd2044);
    run_cyc();
    chk("t5_done", 32'(s_done), 32'd1);
    chk("t5_no_rbufs", 32'(n_rbufs), 32'd0);
    chk("t5_no_over", 32'(s_over), 32'd0);
    run_cyc();
    chk("t5_avail8", 32'(s_avail), 32'd8);
`endif

    // Reset during a burst, then a fresh full burst.
    do_reset();
    bus.buf_ctr_C = 16'd1;
    run_cyc();
    chk("t6_over_clr", 32'(s_over), 32'd0);
    chk("t6_idle", 32'(s_busy), 32'd0);
    bus.start_C = 1'b1; run_cyc(); bus.start_C = 1'b0;
    clr_cnt();
    repeat (99) run_cyc();
    reset_C = 1'b1;
    run_cyc();
    reset_C = 1'b0;
    chk("t6_strobe100", 32'(n_strobe), 32'd100);
    run_cyc();
    chk("t6_rst_nostrobe", 32'(s_strobe), 32'd0);
    chk("t6_rst_busy", 32'(s_busy), 32'd0);
    chk("t6_rst_avail", 32'(s_avail), 32'd1);
    bus.start_C = 1'b1; run_cyc(); bus.start_C = 1'b0;
    clr_cnt();
    repeat (2045) run_cyc();
    chk("t6_strobes", 32'(n_strobe), 32'd2044);
    chk("t6_done", 32'(n_done), 32'd1);
    run_cyc();

    // Random bursts against a word-count model.
    do_reset();
    model_rd = 0;
    for (int t = 0; t < 25; t++) begin
      int unsigned nrx, w, pend, issued, budget;
      bit got_done;
      nrx  = $urandom_range(1, 6);
      w    = nrx * CHANS * 3 + 4;
      pend = $urandom_range(0, 3);
      bus.nrx_samps  = 8'(nrx);
      bus.buf_ctr_C  = 16'(model_rd + pend);
      bus.word_rdy_C = 1'($urandom_range(0, 1));
      bus.start_C = 1'b1; run_cyc(); bus.start_C = 1'b0;
      chk("rnd_start_avail", 32'(s_avail), pend);
      chk("rnd_start_busy", 32'(s_busy), 32'd0);
      if (pend == 0) begin
        repeat ($urandom_range(1, 3)) begin
          bus.word_rdy_C = 1'($urandom_range(0, 1));
          run_cyc();
          chk("rnd_wait_nostrobe", 32'(s_strobe), 32'd0);
          chk("rnd_wait_busy", 32'(s_busy), 32'd1);
        end
        bus.buf_ctr_C = 16'(model_rd + 1);
        run_cyc();
        chk("rnd_arrive_nostrobe", 32'(s_strobe), 32'd0);
      end
      issued = 0;
      got_done = 1'b0;
      budget = w * 6 + 40;
      while (!got_done && budget > 0) begin
        budget--;
        bus.word_rdy_C = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) bus.nrx_samps = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 31) == 0) bus.start_C = 1'b1;
        run_cyc();
        bus.start_C = 1'b0;
        if (issued == w) begin
          chk("rnd_done", 32'(s_done), 32'd1);
          chk("rnd_done_nostrobe", 32'(s_strobe), 32'd0);
          got_done = 1'b1;
        end else begin
          chk("rnd_strobe", 32'(s_strobe), 32'(bus.word_rdy_C));
          chk("rnd_no_done", 32'(s_done), 32'd0);
          if (bus.word_rdy_C) issued++;
        end
      end
      if (!got_done) chk("rnd_timeout", 32'd0, 32'd1);
      run_cyc();
      model_rd++;
      chk("rnd_end_busy", 32'(s_busy), 32'd0);
      chk("rnd_end_avail", 32'(s_avail), (pend == 0) ? 32'd0 : pend - 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rx_audio_xfer_sched.md
# rx_audio_xfer_sched

CPU-clock-domain read scheduler for the shared rx audio sample buffer. It tracks produced buffers (synced `buf_ctr_C`) against consumed buffers and sizes each host-requested burst from `nrx_samps` and the channel count. It issues paced `get_rx_samp_C` read strobes for exactly one buffer per request. It detects writer-overrun of the buffer memory and triggers a buffer reset.

## Interface
Parameters:
- `CHANS`, 4 — rx channels interleaved per sample (3 words each: i, q, iq3).
- `BUF_DEPTH`, 8 — whole buffers the sample memory holds before the writer laps the reader.

Ports:
- `cpu_clk` in 1 — the block's only clock.
- `reset_C` in 1 — synchronous, active-high reset.
- `buf_ctr_C` in 16 — producer buffer count, already synced to `cpu_clk`; wraps mod 2^16.
- `nrx_samps` in 8 — samples per channel per buffer.
- `start_C` in 1 — host request to read one buffer; single-cycle pulse.
- `word_rdy_C` in 1 — downstream (SPI) can take a word this cycle.
- `get_rx_samp_C` out 1 — read strobe to sample memory; one word per high cycle.
- `busy_C` out 1 — transfer or recovery in progress.
- `done_C` out 1 — one-cycle pulse when a full buffer has been read.
- `avail_C` out 16 — `buf_ctr_C - rd_ctr`, mod 2^16 (buffers pending).
- `overrun_C` out 1 — sticky overrun flag.
- `reset_bufs_C` out 1 — one-cycle pulse requesting reset of the producer and memory pointers.

## Operation
- Words per buffer: `W = nrx_samps*CHANS*3 + 4` (3 ticks words + 1 counter word). Computed at 14 bits minimum, latched at start. Later `nrx_samps` changes do not affect an active burst.
- `rd_ctr` is a 16-bit consumed-buffer counter, reset 0, incremented in DONE.
- States:
  - IDLE: `start_C` with `nrx_samps==0` is ignored. Otherwise latch `rem<=W`. Go to READ if `avail_C!=0`, else WAIT.
  - WAIT: go to READ when `avail_C!=0`.
  - READ: `get_rx_samp_C = word_rdy_C` (combinational from state). Each strobe does `rem<=rem-1`. A strobe with `rem==1` goes to DONE.
  - DONE: `done_C=1`, `rd_ctr<=rd_ctr+1`, then IDLE.
  - RECOVER: see overrun.
- `start_C` outside IDLE is ignored (no queueing).
- `busy_C` is high in WAIT, READ, DONE and RECOVER.

## Timing
- Reset values: state IDLE; `rd_ctr=0`, `rem=0`; all outputs 0 (`avail_C` reflects `buf_ctr_C`).
- `start_C` at cycle N with a buffer pending: state READ at N+1. First strobe at N+1 if `word_rdy_C` is high.
- With `word_rdy_C` held high, W consecutive strobes occur over cycles N+1..N+W. `done_C` is high at N+W+1 and `busy_C` falls at N+W+2.
- `word_rdy_C` low in READ stalls with no strobe; `rem` holds.
- Buffer arrives while in WAIT at cycle M: READ at M+1.
- `buf_ctr_C` wrapping 0xFFFF→0 is handled by modular subtraction; `avail_C` stays correct.
- `reset_C` mid-burst: the next cycle is IDLE with no strobe, all counters 0, and `overrun_C` cleared.

## Configuration
- `RX_XFER_OVERRUN_EN` defined:
  - If `avail_C > BUF_DEPTH` in any state except RECOVER, the next cycle is RECOVER. On entry: `reset_bufs_C` pulses for one cycle, `overrun_C<=1` (sticky until `reset_C`), `rd_ctr<=0`, `rem<=0`, and any burst is aborted with no `done_C`.
  - RECOVER holds until `buf_ctr_C==0`, then goes to IDLE.
  - Overrun has priority over a same-cycle final strobe: that strobe still occurs, but DONE is skipped.
- Macro undefined:
  - No overrun logic.
  - `overrun_C` and `reset_bufs_C` are tied 0 and RECOVER is unreachable.
  - `avail_C` may exceed `BUF_DEPTH` silently.

## Test plan
- `CHANS=4`, `nrx_samps=170`, `buf_ctr_C=1`, `word_rdy_C=1`, pulse `start_C` → exactly 2044 strobes; `done_C` on the following cycle; `avail_C` goes 1→0.
- `buf_ctr_C=0`, pulse `start_C` → WAIT with `busy_C=1` and no strobes. Set `buf_ctr_C=1` → strobes begin next cycle.
- `nrx_samps=1`, toggle `word_rdy_C` 1,0,1,0… → 16 strobes spread over 31 cycles; `rem` holds on low cycles.
- `rd_ctr=0xFFFF`, `buf_ctr_C` steps 0xFFFF→0x0000 → `avail_C=1`; a transfer completes normally and `rd_ctr` becomes 0.
- With `RX_XFER_OVERRUN_EN`: mid-burst set `buf_ctr_C=9` (`rd_ctr=0`) → one `reset_bufs_C` pulse, `overrun_C=1`, strobes stop, no `done_C`; IDLE after `buf_ctr_C=0`. Without the macro, the same stimulus → burst completes and `overrun_C` stays 0.
- `reset_C` asserted at strobe 100 of 2044 → next cycle shows no strobe, `busy_C=0`, counters 0; a new `start_C` reads a full 2044 words.
